// File: rtl/fabric_pad_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_pad_counter_pkg
//  Description : Shared constants and types for the fabric pad counter:
//                pad counts, pad indices, fixed output-enable mask, and
//                the counter action decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package fabric_pad_counter_pkg;

    localparam int NUM_IO      = 10;
    localparam int CTRL_PADS   = 2;
    localparam int CNT_WIDTH   = NUM_IO - CTRL_PADS;

    localparam int PAD_CLR     = 0;
    localparam int PAD_EN      = 1;
    localparam int PAD_CNT_LSB = 2;

    // Low control pads are inputs (oeb=1), counter pads always drive.
    localparam logic [NUM_IO-1:0] OEB_MASK = 10'h003;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_CLEAR = 2'd1,
        ACT_INC   = 2'd2
    } cnt_action_e;

    // Clear has priority over enable.
    function automatic cnt_action_e decode_action(input logic clr, input logic en);
        if (clr) return ACT_CLEAR;
        if (en)  return ACT_INC;
        return ACT_HOLD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fabric_pad_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_pad_counter_if
//  Description : Pad bank bundle for the fabric pad counter.
//                io_in  : pad input values  ([0]=clear, [1]=enable)
//                io_out : pad output values
//                io_oeb : output-enable-bar per pad (0=drive, 1=input)
//                master : pad environment (drives io_in)
//                slave  : user design (drives io_out / io_oeb)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fabric_pad_counter_if;
    import fabric_pad_counter_pkg::*;

    logic [NUM_IO-1:0] io_in;
    logic [NUM_IO-1:0] io_out;
    logic [NUM_IO-1:0] io_oeb;

    modport master (
        output io_in,
        input  io_out,
        input  io_oeb
    );

    modport slave (
        input  io_in,
        output io_out,
        output io_oeb
    );

endinterface
`default_nettype wire

// File: rtl/fabric_pad_counter_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pad_sync2
//  Description : Parameterised-width two-flop synchronizer with
//                asynchronous active-low reset to zero.
//                clk    : sampling clock
//                resetn : async active-low reset
//                d_in   : asynchronous inputs
//                q_out  : synchronized outputs (2 cycles of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module pad_sync2
    import fabric_pad_counter_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic [WIDTH-1:0] d_in,
    output logic      [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] stage1_d, stage1_q;
    logic [WIDTH-1:0] stage2_d, stage2_q;

    always_comb begin
        stage1_d = d_in;
        stage2_d = stage1_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign q_out = stage2_q;

endmodule
`default_nettype wire

// File: rtl/fabric_pad_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_pad_counter
//  Description : Gold model of the eFPGA user design: an 8-bit up-counter
//                presented on a 10-pad bidirectional bank.
//                clk    : rising-edge clock
//                resetn : async active-low reset (count -> 0 immediately)
//                pads   : pad bank (slave modport)
//                         io_in[0] sync clear, io_in[1] count enable,
//                         io_in[9:2] ignored
//                         io_out = {count, 2'b00}, io_oeb = 10'h003
//                Build option INPUT_SYNC_EN: io_in[1:0] pass through a
//                two-flop synchronizer (pad_sync2) before the counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fabric_pad_counter
    import fabric_pad_counter_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            resetn,
    fabric_pad_counter_if.slave  pads
);

    logic [CTRL_PADS-1:0]  w_ctrl;
    cnt_action_e           w_action;
    logic [CNT_WIDTH-1:0]  count_d, count_q;
    logic                  w_unused_upper;

`ifdef INPUT_SYNC_EN
    pad_sync2 #(
        .WIDTH (CTRL_PADS)
    ) u_ctrl_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_in   (pads.io_in[CTRL_PADS-1:0]),
        .q_out  (w_ctrl)
    );
`else
    assign w_ctrl = pads.io_in[CTRL_PADS-1:0];
`endif

    // Upper pads are outputs; their input values are intentionally ignored.
    assign w_unused_upper = ^pads.io_in[NUM_IO-1:CTRL_PADS];

    assign w_action = decode_action(w_ctrl[PAD_CLR], w_ctrl[PAD_EN]);

    always_comb begin
        count_d = count_q;
        unique case (w_action)
            ACT_CLEAR: count_d = '0;
            ACT_INC:   count_d = count_q + CNT_WIDTH'(1);  // wraps 0xFF -> 0x00
            default:   count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Output straight from the register: no extra pipeline stage.
    assign pads.io_out = {count_q, {PAD_CNT_LSB{1'b0}}};
    assign pads.io_oeb = OEB_MASK;

endmodule
`default_nettype wire

// File: tb/tb_fabric_pad_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fabric_pad_counter
//  Description : Self-checking bench for fabric_pad_counter. Table-driven
//                vectors plus hand-written sequences; an independent
//                cycle model pushes expected pad outputs into a queue that
//                is popped at each falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric_pad_counter;
    import fabric_pad_counter_pkg::*;

`ifdef INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic resetn;

    fabric_pad_counter_if pads ();

    fabric_pad_counter dut (
        .clk    (clk),
        .resetn (resetn),
        .pads   (pads)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Independent reference state
    logic [7:0] m_count;
    logic [1:0] m_s1, m_s2;
    logic [9:0] sb_q[$];

    typedef struct {
        logic [9:0] in;
        logic [7:0] cnt_direct;
        logic [7:0] cnt_sync;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 8'h00;
        m_s1    = 2'b00;
        m_s2    = 2'b00;
    endtask

    // Drive one input word, take one rising edge, compare at the falling edge.
    task automatic step(input logic [9:0] in);
        logic [1:0] c;
        logic [9:0] exp;
        pads.io_in = in;
        @(posedge clk);
`ifdef INPUT_SYNC_EN
        c    = m_s2;
        m_s2 = m_s1;
        m_s1 = in[1:0];
`else
        c = in[1:0];
`endif
        if (c[0])      m_count = 8'h00;
        else if (c[1]) m_count = m_count + 8'h01;
        sb_q.push_back({m_count, 2'b00});
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 10'h000, 10'h3FF);
        end else begin
            exp = sb_q.pop_front();
            check("io_out", pads.io_out, exp);
        end
        if (pads.io_oeb !== 10'h003) check("io_oeb", pads.io_oeb, 10'h003);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //               in       direct  sync
        tbl[0]  = '{10'h002, 8'd1, 8'd0};
        tbl[1]  = '{10'h002, 8'd2, 8'd0};
        tbl[2]  = '{10'h002, 8'd3, 8'd1};
        tbl[3]  = '{10'h3FC, 8'd3, 8'd2};
        tbl[4]  = '{10'h3FE, 8'd4, 8'd3};
        tbl[5]  = '{10'h003, 8'd0, 8'd3};
        tbl[6]  = '{10'h002, 8'd1, 8'd4};
        tbl[7]  = '{10'h001, 8'd0, 8'd0};
        tbl[8]  = '{10'h000, 8'd0, 8'd1};
        tbl[9]  = '{10'h000, 8'd0, 8'd0};
        tbl[10] = '{10'h000, 8'd0, 8'd0};

        // Reset held from time zero, before any clock edge
        resetn      = 1'b0;
        pads.io_in  = 10'h000;
        model_reset();
        #1;
        check("reset_out_pre_edge", pads.io_out, 10'h000);
        check("reset_oeb_pre_edge", pads.io_oeb, 10'h003);
        #7;
        check("reset_out_held", pads.io_out, 10'h000);
        check("reset_oeb_held", pads.io_oeb, 10'h003);
        @(negedge clk);
        resetn = 1'b1;

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            logic [7:0] e;
            step(tbl[i].in);
            e = (LAT == 0) ? tbl[i].cnt_direct : tbl[i].cnt_sync;
            check("table", pads.io_out, {e, 2'b00});
        end

        // Clear wins over enable after a nonzero count
        for (int i = 0; i < 5; i++) step(10'h002);
        check("pre_clear_nonzero", pads.io_out, 10'((5 - LAT) << 2));
        for (int i = 0; i < 5; i++) step(10'h003);
        check("clear_priority", pads.io_out, 10'h000);

        // Counting for 100 cycles
        for (int i = 0; i < 3; i++) step(10'h001);
        for (int n = 1; n <= 100; n++) begin
            step(10'h002);
            if (n == 10 + LAT) check("count_10", pads.io_out, 10'h028);
            if (n == 1 + LAT)  check("first_increment", pads.io_out, 10'h004);
        end

        // Wrap-around
        for (int i = 0; i < 3; i++) step(10'h001);
        for (int i = 0; i < 255 + LAT; i++) step(10'h002);
        check("count_ff", pads.io_out, 10'h3FC);
        step(10'h002);
        check("wrap_zero", pads.io_out, 10'h000);

        // Hold with upper pads toggling
        for (int i = 0; i < 20; i++) step((i % 2) ? 10'h3FC : 10'h2A8);

        // Async reset mid-count at 0x37
        for (int i = 0; i < 3; i++) step(10'h001);
        for (int i = 0; i < 55 + LAT; i++) step(10'h002);
        check("count_37", pads.io_out, 10'h0DC);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_reset_out", pads.io_out, 10'h000);
        check("async_reset_oeb", pads.io_oeb, 10'h003);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) step(10'h002);
        check("restart_after_reset", pads.io_out, 10'((3 - LAT) << 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fabric_pad_counter.md
Name: fabric_pad_counter

Overview:
- Reference user design ("gold" model) for the eFPGA user project: an 8-bit up-counter driven through a 10-pad bidirectional I/O bank.
- Same pad-level behaviour as the bitstream loaded into the fabric; the bench compares the two cycle by cycle.
- Pads 0–1 are control inputs; pads 2–9 drive the counter value.

Parameters:
- NUM_IO, 10, number of I/O pads.
- CTRL_PADS, 2, number of low pads used as inputs; counter width is NUM_IO-CTRL_PADS (8).

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous, active-low reset.
- io_in  input  NUM_IO  pad inputs; [0]=sync clear, [1]=count enable, [9:2] ignored.
- io_out  output  NUM_IO  pad output values.
- io_oeb  output  NUM_IO  output-enable-bar per pad; 0=pad drives, 1=pad is input.

Behaviour:
- Interface: one clock `clk`; reset `resetn` is asynchronous and active-low.
- State is one register `count[7:0]`.
- resetn=0: count=0 immediately, with no clock edge needed. io_out=0x000 while reset is held.
- Each rising clk edge, with resetn=1, in this priority:
  - io_in[0]=1: count<=0. Clear wins over enable.
  - else io_in[1]=1: count<=count+1, modulo 256 (0xFF -> 0x00, no flag).
  - else: count holds.
- io_out = {count, 2'b00}, driven combinationally from the register.
  - io_out[1:0] are constant 0.
  - No extra output pipeline stage; a new count is visible in the same cycle as the edge that produced it.
- io_oeb is the constant 10'b00_0000_0011 (0x003), also during reset.
  - Fabric equivalent T_top = ~io_oeb = 0x3FC.
- io_in[9:2] have no effect.
- X/Z on io_in[1:0] is not defined; the bench drives known values at all times.
- Releasing resetn between edges: counting resumes from 0 on the next edge.

Optional Feature:
- Macro INPUT_SYNC_EN.
- Defined: io_in[1:0] each pass through a 2-flop synchronizer before the counter logic.
  - Synchronizer flops reset to 0 asynchronously on resetn.
  - Clear and enable take effect 2 cycles later than without the macro.
- Undefined: io_in[1:0] feed the counter logic directly, with the timing above.
- The fabric bitstream must be built with the matching setting.

Decomposition:
- Shared package `fabric_pad_counter_pkg` holds:
  - pad index constants PAD_CLR=0, PAD_EN=1, PAD_CNT_LSB=2.
  - OEB_MASK=10'h003.
  - CNT_WIDTH derived from NUM_IO and CTRL_PADS.
- One natural sub-module, `pad_sync2`: a parameterised-width 2-flop synchronizer with async active-low reset. It is instantiated only under INPUT_SYNC_EN.

Test Plan:
- Reset: resetn=0 for 10 ns with io_in=0 -> io_out=0x000 and io_oeb=0x003 throughout, including before any clk edge.
- Clear and enable together: io_in=0x003 for 5 edges after a nonzero count -> io_out=0x000 (clear priority).
- Counting: io_in=0x002 after clear -> at each negedge, io_out=(n<<2) after n rising edges, e.g. 0x028 after 10 edges. Check for 100 cycles; io_oeb stays 0x003.
- Wrap-around: enable for 255 edges -> io_out=0x3FC; next edge -> io_out=0x000.
- Hold and ignored pads: io_in=0x3FC (enable=0, clear=0, upper pads toggling) -> count unchanged for 20 edges.
- Async reset mid-count: at count 0x37, pulse resetn low between edges -> io_out=0x000 before the next edge; counting restarts from 0.
- INPUT_SYNC_EN build: same stimulus as the counting case -> the first increment appears 2 edges later.
